// File: rtl/usb_cdc_tx_arb.sv
// Two-requester round-robin arbiter feeding the USB CDC IN-endpoint TX FIFO.
// Optional idle timeout enabled by defining USB_CDC_TX_ARB_TIMEOUT_EN.
module usb_cdc_tx_arb #(
   parameter int DW        = 8,
   parameter int TO_CYCLES = 16
) (
   input  logic            clk,
   input  logic            rst_n,
   input  logic [1:0]      req_valid,
   input  logic [2*DW-1:0] req_data,
   input  logic [1:0]      req_last,
   output logic [1:0]      req_ready,
   input  logic [3:0]      burst_max,
   input  logic            tx_fifo_full,
   output logic            tx_fifo_wr,
   output logic [DW-1:0]   tx_fifo_wdata,
   output logic [1:0]      grant,
   output logic            busy,
   output logic            timeout_o
);

   typedef enum logic [1:0] {IDLE, GNT0, GNT1} state_t;

   state_t     state;
   state_t     state_nxt;
   logic [3:0] beat_cnt;
   logic       last_served;
   logic       last_served_nxt;
   logic       owner;
   logic       own_valid;
   logic       beat;
   logic       timeout_hit;

   assign owner     = (state == GNT1);
   assign own_valid = owner ? req_valid[1] : req_valid[0];
   assign busy      = (grant != 2'b00);

`ifdef USB_CDC_TX_ARB_TIMEOUT_EN
   localparam int TW = $clog2(TO_CYCLES + 1);

   logic [TW-1:0] to_cnt;

   // Flag the cycle that completes TO_CYCLES consecutive idle cycles of the owner
   always_comb begin
      timeout_hit = 1'b0;
      if (state != IDLE && !own_valid && to_cnt == TW'(TO_CYCLES - 1))
         timeout_hit = 1'b1;
   end

   // Count consecutive cycles in which the current owner presents no data
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n)
         to_cnt <= '0;
      else if (state == IDLE || own_valid || timeout_hit)
         to_cnt <= '0;
      else
         to_cnt <= to_cnt + TW'(1);
   end

   assign timeout_o = timeout_hit;
`else
   assign timeout_hit = 1'b0;
   assign timeout_o   = 1'b0;
`endif

   // Next-state selection and all datapath outputs, decoded from the current state
   always_comb begin
      state_nxt       = state;
      last_served_nxt = last_served;
      grant           = 2'b00;
      req_ready       = 2'b00;
      tx_fifo_wr      = 1'b0;
      tx_fifo_wdata   = '0;
      beat            = 1'b0;
      case (state)
         IDLE: begin
            if (req_valid[0] && req_valid[1])
               state_nxt = last_served ? GNT0 : GNT1;
            else if (req_valid[0])
               state_nxt = GNT0;
            else if (req_valid[1])
               state_nxt = GNT1;
         end
         GNT0, GNT1: begin
            grant            = owner ? 2'b10 : 2'b01;
            req_ready[owner] = ~tx_fifo_full;
            beat             = own_valid & ~tx_fifo_full;
            tx_fifo_wr       = beat;
            tx_fifo_wdata    = owner ? req_data[2*DW-1:DW] : req_data[DW-1:0];
            if ((beat && (req_last[owner] || beat_cnt == burst_max - 4'd1)) || timeout_hit) begin
               state_nxt       = IDLE;
               last_served_nxt = owner;
            end
         end
         default: state_nxt = IDLE;
      endcase
   end

   // State, round-robin pointer and per-grant beat counter
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state       <= IDLE;
         beat_cnt    <= 4'd0;
         last_served <= 1'b1;
      end else begin
         state       <= state_nxt;
         last_served <= last_served_nxt;
         if (state == IDLE)
            beat_cnt <= 4'd0;
         else if (beat)
            beat_cnt <= beat_cnt + 4'd1;
      end
   end

endmodule

// File: doc/usb_cdc_tx_arb.md
USB_CDC_TX_ARB -- requirements
Module: usb_cdc_tx_arb

Interface
REQ-001 SHALL have parameter: DW, 8, byte width of requester and FIFO write data.
REQ-002 SHALL have parameter: TO_CYCLES, 16, idle-timeout length in clock cycles (used only when USB_CDC_TX_ARB_TIMEOUT_EN is defined).
REQ-003 SHALL have port: clk  input  1  single clock for all logic.
REQ-004 SHALL have port: rst_n  input  1  reset, asynchronous, active-low.
REQ-005 SHALL have ports: req_valid  input  2; req_data  input  2*DW, requester i in bits [i*DW +: DW]; req_last  input  2, last byte of message; req_ready  output  2.
REQ-006 SHALL have ports: burst_max  input  4, max bytes per grant, 0 = 16; tx_fifo_full  input  1; tx_fifo_wr  output  1; tx_fifo_wdata  output  DW.
REQ-007 SHALL have status ports: grant  output  2, one-hot owner; busy  output  1, grant held; timeout_o  output  1, one-cycle pulse.

Function
REQ-008 SHALL arbitrate two byte-stream requesters onto the single TX FIFO write port feeding the USB CDC IN endpoint.
REQ-009 SHALL implement FSM states IDLE, GNT0, GNT1; grant = 2'b01 in GNT0, 2'b10 in GNT1, 2'b00 in IDLE; busy = grant != 0.
REQ-010 IDLE: one requester valid -> grant it next cycle; both valid -> grant the one not served last (round-robin pointer); none -> stay IDLE.
REQ-011 In GNTn: req_ready[n] = ~tx_fifo_full, combinational; req_ready of the other requester and of both in IDLE SHALL be 0.
REQ-012 In GNTn: tx_fifo_wr = req_valid[n] & ~tx_fifo_full; tx_fifo_wdata = req_data of n; in IDLE tx_fifo_wr = 0, tx_fifo_wdata = 0.
REQ-013 A beat SHALL be req_valid[n] & req_ready[n]; no beat SHALL be written while tx_fifo_full = 1 (back-pressure, grant held).
REQ-014 4-bit beat counter SHALL clear on grant entry and increment per beat, wrapping modulo 16.
REQ-015 Grant SHALL release (-> IDLE next cycle) after a beat with req_last[n] = 1 or a beat with counter == burst_max - 1 (mod 16, so burst_max = 0 gives 16 beats).
REQ-016 On release the round-robin pointer SHALL record n as last served; exactly one IDLE bubble cycle SHALL separate consecutive grants.
REQ-017 Latency: first byte SHALL reach tx_fifo_wr at earliest one cycle after req_valid rises in IDLE.
REQ-018 burst_max SHALL be sampled continuously; changing it mid-grant takes effect on the next beat comparison.
REQ-019 Data SHALL never be dropped, duplicated or reordered within a requester stream.

Reset
REQ-020 On rst_n low, asynchronously: state IDLE, counter 0, pointer = last served 1 (requester 0 wins first tie), timeout counter 0.
REQ-021 During and immediately after reset: grant = 0, busy = 0, req_ready = 0, tx_fifo_wr = 0, tx_fifo_wdata = 0, timeout_o = 0.
REQ-022 Reset mid-grant SHALL abandon the burst without a partial write in the reset cycle.

Configuration
REQ-023 Macro USB_CDC_TX_ARB_TIMEOUT_EN defined: in GNTn, a counter SHALL count consecutive cycles with req_valid[n] = 0; reaching TO_CYCLES SHALL release the grant to IDLE, pulse timeout_o one cycle, and update the pointer as in REQ-016; any beat or valid clears the counter.
REQ-024 Macro undefined: no timeout logic; grant held indefinitely until REQ-015; timeout_o tied 0.

Verification
REQ-025 Reset, r0 valid 3 bytes 0xA1,0xA2,0xA3 last on third, burst_max=8 -> tx_fifo_wr 3 consecutive cycles starting cycle 1, grant 01, IDLE next.
REQ-026 Both valid continuously, burst_max=2, no last -> byte order r0,r0,bubble,r1,r1,bubble,r0,r0; grant alternates 01,10.
REQ-027 burst_max=0, r1 streams 20 bytes no last -> 16 writes, release, bubble, re-grant r1 for remaining 4.
REQ-028 tx_fifo_full held 1 for 5 cycles mid-burst -> tx_fifo_wr 0, req_ready 0, grant unchanged; resumes with the same pending byte.
REQ-029 Macro defined, TO_CYCLES=16, r0 granted then drops valid -> IDLE after 16 cycles, timeout_o one pulse; macro undefined -> grant held, timeout_o 0.
REQ-030 rst_n asserted mid-burst on r1 -> all outputs 0 immediately; after release, tie resolves to r0.
